ysyx_25030093_ifu: RTL
======================

Name: ysyx_25030093_ifu

Overview:
Instruction fetch unit that replaces the direct combinational instruction read.
- Accepts a fetch PC from the PC unit over a valid/ready handshake.
- Issues one word read on a request/response memory bus.
- Presents the instruction, its PC and a fault code to the IDU over a valid/ready handshake.
- Supports one fetch in flight, misalignment detection, bus-error and timeout faults, flush with in-flight response draining, and a retired-fetch counter.

Parameters:
TIMEOUT, 256, number of cycles to wait for a memory response before raising a timeout fault; 0 disables the timeout.
RESET_PC_OUT, 32'h0, value driven on out_pc after reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
flush  input  1  discard the current fetch (redirect, trap).
in_valid  input  1  PC unit offers a fetch PC.
in_ready  output  1  IFU can accept a fetch PC.
in_pc  input  32  fetch address.
mem_req_valid  output  1  read request valid.
mem_req_ready  input  1  memory accepts the request.
mem_req_addr  output  32  word address of the request (the accepted PC).
mem_rsp_valid  input  1  read data valid; single-cycle pulse, always accepted.
mem_rsp_data  input  32  read data.
mem_rsp_err  input  1  bus error, qualified by mem_rsp_valid.
out_valid  output  1  instruction available to the IDU.
out_ready  input  1  IDU consumes the instruction.
out_pc  output  32  PC of the presented instruction.
out_inst  output  32  instruction word; 0 when out_fault!=0.
out_fault  output  2  fault code: 00 none, 01 misaligned, 10 bus error, 11 timeout.
fetch_cnt  output  32  count of completed out handshakes; wraps modulo 2^32.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Reset state: IDLE. out_pc=RESET_PC_OUT, out_inst=0, out_fault=0, fetch_cnt=0, internal PC register=0, timer=0.
- Reset-derived outputs: out_valid=0, mem_req_valid=0, in_ready=1 (when flush=0).
- Reset priority: reset overrides everything, including mid-transaction. Any response arriving after reset is ignored unless the block is in WAIT or DRAIN.
- Output sources:
  - in_ready = (state==IDLE) & ~flush.
  - mem_req_valid = (state==REQ).
  - out_valid = (state==HOLD).
  - mem_req_addr, out_pc, out_inst and out_fault are registered outputs.
- IDLE: on in_valid & in_ready, latch in_pc.
  - If in_pc[1:0]!=0: load out_fault=01, out_inst=0, go to HOLD. No bus request is issued.
  - Otherwise go to REQ.
- REQ: hold mem_req_valid=1 with a stable address until mem_req_ready. On the handshake, clear the timer and go to WAIT.
- WAIT: the timer increments every cycle.
  - On mem_rsp_valid: latch out_inst = err ? 0 : data and out_fault = err ? 10 : 00, then go to HOLD.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: out_fault=11, out_inst=0, go to HOLD.
  - The bus watchdog aborts timed-out transactions, so no late response follows a timeout.
- HOLD: out_valid=1 and all out_* stay stable until out_ready. On the handshake, fetch_cnt increments and the state goes to IDLE.
- Latency: with zero memory wait, out_valid rises 3 cycles after the in handshake edge (REQ, WAIT, HOLD). No new fetch is accepted while a fetch is in flight.
- Flush (sampled each cycle; highest priority after reset):
  - IDLE: nothing accepted; stay in IDLE.
  - REQ: if mem_req_ready is also high that cycle, the request was issued, so go to DRAIN. Otherwise go to IDLE and withdraw the request.
  - WAIT: if mem_rsp_valid is also high, drop the response and go to IDLE. Otherwise go to DRAIN.
  - HOLD: drop the instruction, go to IDLE; fetch_cnt is unchanged even if out_ready=1 that cycle.
  - DRAIN: stay in DRAIN.
- DRAIN: in_ready=0, out_valid=0, timer running. On mem_rsp_valid, discard the data and go to IDLE. On timeout expiry (TIMEOUT!=0), go to IDLE with no fault reported.
- Unexpected responses: mem_rsp_valid in IDLE, REQ or HOLD is ignored.
- Timer: 32-bit; saturates when TIMEOUT=0.

Test Plan:
1. Basic fetch: rst low 2 cycles, then in_pc=0x80000000, mem_req_ready=1, response 1 cycle later with 0x00000413 -> mem_req_addr=0x80000000; out_valid 3 cycles after accept with out_inst=0x00000413, out_fault=00; after out_ready, fetch_cnt=1 and in_ready=1.
2. Misaligned: in_pc=0x80000002 -> mem_req_valid never rises; next cycle out_valid=1, out_fault=01, out_inst=0, out_pc=0x80000002.
3. Backpressure plus bus error: response with mem_rsp_err=1 and data 0x12345678, out_ready low for 5 cycles -> out_inst=0 and out_fault=10 held stable; in_ready=0; fetch_cnt unchanged until the handshake, then +1.
4. Flush in WAIT: flush one cycle, then a response of 0xdeadbeef 3 cycles later -> out_valid stays 0, state DRAIN then IDLE. Next fetch 0x80000004 returns 0x00100073 correctly; fetch_cnt counts only that one.
5. Timeout: TIMEOUT=16, mem_req_ready=1, no response -> out_fault=11 with out_valid on the cycle after 16 WAIT cycles. Then assert flush together with out_ready in HOLD -> dropped, fetch_cnt unchanged.
6. Reset mid-operation: rst=0 during WAIT, then a response arrives -> block returns to IDLE with all reset values; the response is ignored; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one fetch in flight over a request/response memory bus,
// with misalignment, bus-error and timeout faults, flush draining and a retired-fetch counter.
module ysyx_25030093_ifu #(
   parameter int unsigned TIMEOUT      = 256,
   parameter logic [31:0] RESET_PC_OUT = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [1:0]  out_fault,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN
   } state_e;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_MISALGN = 2'b01;
   localparam logic [1:0] FAULT_BUS     = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

   localparam bit          TIMER_EN   = (TIMEOUT != 0);
   localparam logic [31:0] TIMER_LAST = TIMER_EN ? 32'(TIMEOUT - 1) : 32'd0;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [1:0]  out_fault_q, out_fault_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] timer_inc;
   logic        timer_expired;

   assign in_ready      = (state_q == S_IDLE) & ~flush;
   assign mem_req_valid = (state_q == S_REQ);
   assign out_valid     = (state_q == S_HOLD);
   assign mem_req_addr  = pc_q;
   assign out_pc        = out_pc_q;
   assign out_inst      = out_inst_q;
   assign out_fault     = out_fault_q;
   assign fetch_cnt     = fetch_cnt_q;

   // >= rather than == so a flush landing on the last WAIT cycle still expires in DRAIN.
   assign timer_inc     = (timer_q == '1) ? timer_q : timer_q + 32'd1;
   assign timer_expired = TIMER_EN && (timer_q >= TIMER_LAST);

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      out_fault_d = out_fault_q;
      fetch_cnt_d = fetch_cnt_q;
      timer_d     = timer_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               pc_d = in_pc;
               if (in_pc[1:0] != 2'b00) begin
                  out_pc_d    = in_pc;
                  out_inst_d  = 32'd0;
                  out_fault_d = FAULT_MISALGN;
                  state_d     = S_HOLD;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) timer_d = 32'd0;
            if (flush)              state_d = mem_req_ready ? S_DRAIN : S_IDLE;
            else if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_inc;
            if (flush) begin
               state_d = mem_rsp_valid ? S_IDLE : S_DRAIN;
            end else if (mem_rsp_valid) begin
               out_pc_d    = pc_q;
               out_inst_d  = mem_rsp_err ? 32'd0 : mem_rsp_data;
               out_fault_d = mem_rsp_err ? FAULT_BUS : FAULT_NONE;
               state_d     = S_HOLD;
            end else if (timer_expired) begin
               out_pc_d    = pc_q;
               out_inst_d  = 32'd0;
               out_fault_d = FAULT_TIMEOUT;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (out_ready) begin
               fetch_cnt_d = fetch_cnt_q + 32'd1;
               state_d     = S_IDLE;
            end
         end
         S_DRAIN: begin
            timer_d = timer_inc;
            if (!flush && (mem_rsp_valid || timer_expired)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: reset is sampled on the clock edge; nonblocking updates keep all flops in step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= 32'd0;
         out_pc_q    <= RESET_PC_OUT;
         out_inst_q  <= 32'd0;
         out_fault_q <= FAULT_NONE;
         fetch_cnt_q <= 32'd0;
         timer_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
         out_fault_q <= out_fault_d;
         fetch_cnt_q <= fetch_cnt_d;
         timer_q     <= timer_d;
      end
   end

endmodule
